// File: rtl/one_wire_rom_checker.sv
// 1-Wire ROM-ID checker: collects the 64 ROM bits over valid/ready, runs the
// reflected Dallas CRC-8 serially and reports pass/fail, timeout or abort.
module one_wire_rom_checker #(
    parameter int unsigned ROM_BITS       = 64,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter logic [7:0]  CRC_POLY_REFL  = 8'h8C
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                bit_valid,
    input  logic                bit_in,
    output logic                bit_ready,
    output logic                busy,
    output logic                done,
    output logic                crc_ok,
    output logic                timeout,
    output logic                aborted,
    output logic [ROM_BITS-1:0] rom_id,
    output logic [7:0]          family_code,
    output logic [7:0]          crc_value
);

    localparam int unsigned     IdxW        = $clog2(ROM_BITS);
    localparam int unsigned     CntW        = IdxW + 1;
    localparam logic [CntW-1:0] LastBit     = CntW'(ROM_BITS - 1);
    localparam logic [15:0]     TimeoutLast = TIMEOUT_CYCLES - 16'd1;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StCheck,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          crc_q, crc_d;
    logic [ROM_BITS-1:0] rom_q, rom_d;
    logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [15:0]         tmo_q, tmo_d;
    logic                crc_ok_q, crc_ok_d;
    logic                timeout_q, timeout_d;
    logic                aborted_q, aborted_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;

    logic [IdxW-1:0]     bit_idx;
    logic                crc_fb;

    assign bit_idx = bit_cnt_q[IdxW-1:0];
    assign crc_fb  = crc_q[0] ^ bit_in;

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        rom_d     = rom_q;
        bit_cnt_d = bit_cnt_q;
        tmo_d     = tmo_q;
        crc_ok_d  = crc_ok_q;
        timeout_d = timeout_q;
        aborted_d = aborted_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    crc_d     = 8'h00;
                    rom_d     = '0;
                    bit_cnt_d = '0;
                    tmo_d     = 16'd0;
                    crc_ok_d  = 1'b0;
                    timeout_d = 1'b0;
                    aborted_d = 1'b0;
                    state_d   = StCollect;
                end
            end

            StCollect: begin
                // Abort outranks both a simultaneous accept and a timeout expiry.
                if (abort) begin
                    aborted_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = StIdle;
                end else if (bit_valid) begin
                    rom_d[bit_idx] = bit_in;
                    crc_d          = (crc_q >> 1) ^ (crc_fb ? CRC_POLY_REFL : 8'h00);
                    bit_cnt_d      = bit_cnt_q + CntW'(1);
                    tmo_d          = 16'd0;
                    if (bit_cnt_q == LastBit) begin
                        state_d = StCheck;
                    end
                end else if (tmo_q == TimeoutLast) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = StIdle;
                end else if (tmo_q != 16'hFFFF) begin
                    tmo_d = tmo_q + 16'd1;
                end
            end

            StCheck: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = StIdle;
                end else begin
                    crc_ok_d = (crc_q == 8'h00);
                    done_d   = 1'b1;
                    state_d  = StDone;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Handshake and status flags are registered from the next state.
    assign ready_d = (state_d == StCollect);
    assign busy_d  = (state_d == StCollect) || (state_d == StCheck);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            crc_q     <= 8'h00;
            rom_q     <= '0;
            bit_cnt_q <= '0;
            tmo_q     <= 16'd0;
            crc_ok_q  <= 1'b0;
            timeout_q <= 1'b0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            rom_q     <= rom_d;
            bit_cnt_q <= bit_cnt_d;
            tmo_q     <= tmo_d;
            crc_ok_q  <= crc_ok_d;
            timeout_q <= timeout_d;
            aborted_q <= aborted_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign bit_ready   = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign crc_ok      = crc_ok_q;
    assign timeout     = timeout_q;
    assign aborted     = aborted_q;
    assign rom_id      = rom_q;
    assign family_code = rom_q[7:0];
    assign crc_value   = crc_q;

endmodule

// File: tb/tb_one_wire_rom_checker.sv
// Self-checking bench for one_wire_rom_checker: cycle vector table, directed
// corner sequences and randomized reads checked against a CRC reference model.
module tb_one_wire_rom_checker;

    localparam logic [63:0] GOLD = 64'hA200_0000_01B8_1C02;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_ready, busy, done, crc_ok, timeout, aborted;
    logic [63:0] rom_id;
    logic [7:0]  family_code, crc_value;

    int checks = 0;
    int errors = 0;

    one_wire_rom_checker #(
        .ROM_BITS      (64),
        .TIMEOUT_CYCLES(16'd100),
        .CRC_POLY_REFL (8'h8C)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .bit_ready  (bit_ready),
        .busy       (busy),
        .done       (done),
        .crc_ok     (crc_ok),
        .timeout    (timeout),
        .aborted    (aborted),
        .rom_id     (rom_id),
        .family_code(family_code),
        .crc_value  (crc_value)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic start;
        logic abort;
        logic valid;
        logic bin;
        logic exp_ready;
        logic exp_busy;
        logic exp_done;
        logic exp_aborted;
    } vec_t;

    vec_t tbl[9];

    // Dallas CRC-8: x^8+x^5+x^4+1, data shifted in LSB-first.
    function automatic logic [7:0] dallas_crc(input logic [63:0] id, input int nbits);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (c[0] ^ id[i]) c = (c >> 1) ^ 8'h8C;
            else              c = c >> 1;
        end
        return c;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_read(input logic [63:0] id, input int gap, input bit rand_gap,
                            input bit abort_in_done, input string tag);
        logic [7:0] exp_crc;
        int         g;
        int         ready_miss;
        exp_crc    = dallas_crc(id, 64);
        ready_miss = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            g = rand_gap ? int'($urandom_range(gap, 0)) : gap;
            bit_valid = 1'b0;
            for (int k = 0; k < g; k++) step();
            if (bit_ready !== 1'b1) ready_miss++;
            bit_valid = 1'b1;
            bit_in    = id[i];
            step();
        end
        bit_valid = 1'b0;
        check({tag, " done early"}, done, 1'b0);
        check({tag, " busy in check"}, busy, 1'b1);
        check({tag, " ready missing"}, ready_miss, 0);
        step();
        check({tag, " done pulse"}, done, 1'b1);
        check({tag, " crc_ok"}, crc_ok, exp_crc == 8'h00);
        check({tag, " crc_value"}, crc_value, exp_crc);
        check({tag, " rom_id"}, rom_id, id);
        check({tag, " family"}, family_code, id[7:0]);
        check({tag, " timeout"}, timeout, 1'b0);
        abort = abort_in_done;
        step();
        abort = 1'b0;
        check({tag, " done cleared"}, done, 1'b0);
        check({tag, " busy cleared"}, busy, 1'b0);
        check({tag, " aborted"}, aborted, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
        $fatal(1);
    end

    initial begin
        logic [63:0] id;
        int          k;

        // Rows: start abort valid bin | ready busy done aborted
        tbl[0] = 8'b0000_0000;  // idle
        tbl[1] = 8'b0100_0000;  // abort in idle ignored
        tbl[2] = 8'b0011_0000;  // bit in idle not consumed
        tbl[3] = 8'b1000_1100;  // start
        tbl[4] = 8'b1011_1100;  // start ignored, bit 0 = 1 accepted
        tbl[5] = 8'b0100_0011;  // abort
        tbl[6] = 8'b0000_0001;  // aborted sticky
        tbl[7] = 8'b1000_1100;  // start clears aborted
        tbl[8] = 8'b0100_0011;  // abort with no bits

        step();
        check("reset ready", bit_ready, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset crc_ok", crc_ok, 1'b0);
        check("reset timeout", timeout, 1'b0);
        check("reset aborted", aborted, 1'b0);
        check("reset rom_id", rom_id, 64'h0);
        check("reset crc_value", crc_value, 8'h00);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            start     = tbl[i].start;
            abort     = tbl[i].abort;
            bit_valid = tbl[i].valid;
            bit_in    = tbl[i].bin;
            step();
            check($sformatf("vec%0d ready", i), bit_ready, tbl[i].exp_ready);
            check($sformatf("vec%0d busy", i), busy, tbl[i].exp_busy);
            check($sformatf("vec%0d done", i), done, tbl[i].exp_done);
            check($sformatf("vec%0d aborted", i), aborted, tbl[i].exp_aborted);
            if (i == 6) check("vec6 rom_id partial", rom_id, 64'h1);
        end
        start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        check("vec rom_id cleared", rom_id, 64'h0);
        step();

        run_read(GOLD, 0, 1'b0, 1'b0, "golden");
        check("golden crc_ok", crc_ok, 1'b1);
        check("golden crc zero", crc_value, 8'h00);
        check("golden family", family_code, 8'h02);

        id = GOLD ^ (64'h1 << 63);
        run_read(id, 0, 1'b0, 1'b0, "corrupt");
        check("corrupt crc nonzero", crc_value != 8'h00, 1'b1);
        check("corrupt crc_ok", crc_ok, 1'b0);

        run_read(GOLD, 6, 1'b0, 1'b1, "throttled");
        check("throttled crc_ok", crc_ok, 1'b1);

        // Inter-bit timeout after 10 bits.
        id = 64'h2CE;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bit_valid = 1'b1; bit_in = id[i]; step();
        end
        bit_valid = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        check("timeout done latency", k, 100);
        check("timeout flag", timeout, 1'b1);
        check("timeout crc_ok", crc_ok, 1'b0);
        check("timeout rom_id", rom_id, 64'h2CE);
        check("timeout busy", busy, 1'b0);
        step();
        check("timeout sticky", timeout, 1'b1);

        // Abort colliding with the accept of bit 20.
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bit_valid = 1'b1; bit_in = GOLD[i]; step();
        end
        bit_valid = 1'b1; bit_in = 1'b1; abort = 1'b1;
        step();
        bit_valid = 1'b0; abort = 1'b0;
        check("abort flag", aborted, 1'b1);
        check("abort done", done, 1'b1);
        check("abort ready", bit_ready, 1'b0);
        check("abort crc_ok", crc_ok, 1'b0);
        check("abort timeout", timeout, 1'b0);
        check("abort rom_id", rom_id, GOLD & 64'h0000_0000_000F_FFFF);
        step();
        check("abort done once", done, 1'b0);

        // Reset in the middle of a read.
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bit_valid = 1'b1; bit_in = GOLD[i]; step();
        end
        bit_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst ready", bit_ready, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst rom_id", rom_id, 64'h0);
        check("rst crc_value", crc_value, 8'h00);
        check("rst aborted", aborted, 1'b0);
        #3 rst_n = 1'b1;
        step();
        run_read(GOLD, 0, 1'b0, 1'b0, "post-reset");
        check("post-reset crc_ok", crc_ok, 1'b1);

        // Random IDs, half with a correct CRC byte appended.
        for (int n = 0; n < 20; n++) begin
            id = {$urandom, $urandom};
            if ($urandom_range(1, 0) == 1) id[63:56] = dallas_crc(id, 56);
            run_read(id, 3, 1'b1, 1'b0, $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/one_wire_rom_checker.md
# one_wire_rom_checker

Sequencing controller for the 1-Wire ROM-ID check path. It accepts the 64 ROM bits (family code, 48-bit serial, CRC byte) one at a time from the bit-level receiver through a valid/ready handshake. It runs the Dallas CRC-8 over them serially, captures the ROM ID, and reports pass/fail, timeout or abort to the host-side command FSM. It sits between the 1-Wire bit-slot engine and the enumeration/search controller.

## Interface
Parameters:
- `ROM_BITS`, 64: total bits per ROM ID. Fixed at 56 data bits + 8 CRC bits; other values unsupported.
- `TIMEOUT_CYCLES`, 16'd50000: maximum clk cycles allowed between accepted bits before a timeout.
- `CRC_POLY_REFL`, 8'h8C: reflected CRC-8 polynomial (x^8+x^5+x^4+1), applied LSB-first.

Ports:
- `clk`, input, 1: system clock; all logic on rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: single-cycle request to begin a ROM read; honoured only in IDLE.
- `abort`, input, 1: cancels an active read; highest priority after reset.
- `bit_valid`, input, 1: receiver presents a ROM bit.
- `bit_in`, input, 1: ROM bit value, LSB of the family byte first.
- `bit_ready`, output, 1: checker can accept a bit; high only in COLLECT.
- `busy`, output, 1: high in COLLECT and CHECK.
- `done`, output, 1: one-cycle pulse when the result outputs become valid.
- `crc_ok`, output, 1: CRC residue is zero; valid from `done` until the next `start`.
- `timeout`, output, 1: read ended by inter-bit timeout; sticky until the next `start`.
- `aborted`, output, 1: read ended by `abort`; sticky until the next `start`.
- `rom_id`, output, 64: captured ID. Bit 0 is the first bit received.
- `family_code`, output, 8: equals `rom_id[7:0]`.
- `crc_value`, output, 8: running CRC register, for debug.

## Operation
- States: IDLE, COLLECT, CHECK, DONE.
- Reset values: state IDLE. `bit_ready`, `busy`, `done`, `crc_ok`, `timeout` and `aborted` are 0. `rom_id` and `crc_value` are 0. The bit counter and timeout counter are 0.
- IDLE, `start`=1: clear `crc_value`, `rom_id`, `crc_ok`, `timeout`, `aborted`, the bit counter and the timeout counter. Go to COLLECT.
- COLLECT, `bit_valid`=1 (ready is high here):
  - Accept `bit_in` into `rom_id[count]`.
  - Compute fb = `crc_value[0]` ^ `bit_in`.
  - Update `crc_value` <= (`crc_value` >> 1) ^ (fb ? `CRC_POLY_REFL` : 0).
  - Increment count and clear the timeout counter.
  - When the accepted bit is count = ROM_BITS-1, go to CHECK.
- COLLECT, no bit accepted: increment the timeout counter. When it reaches TIMEOUT_CYCLES-1 without an accept, set `timeout`, assert `done`, and go to IDLE. `crc_ok` stays 0.
- CHECK (one cycle): `crc_ok` <= (`crc_value` == 0). Go to DONE.
- DONE (one cycle): `done`=1, then go to IDLE.
- `abort` in COLLECT or CHECK: set `aborted`, pulse `done` the next cycle, and go to IDLE. `crc_ok` stays 0. Partial `rom_id` is retained.
- `abort` in IDLE or DONE is ignored.
- `start` outside IDLE is ignored; no queueing.
- `bit_valid` outside COLLECT is ignored; the bit is not consumed because `bit_ready`=0.
- Reset asserted mid-operation returns all state and outputs to reset values immediately.

## Timing
- `bit_ready` is a registered function of state. Earliest first accept is the cycle after `start`.
- A bit transfers on a rising edge where `bit_valid` and `bit_ready` are both 1. Sustained rate is 1 bit/cycle.
- Latency from the last accepted bit: CHECK 1 cycle, then `done` in the next cycle, i.e. 2 cycles after the final accept edge.
- New `start` is accepted in the cycle after `done`.
- Simultaneous `abort` and a bit accept in COLLECT: abort wins and the bit is dropped.
- Simultaneous `abort` and timeout expiry: report `aborted` only.
- The timeout counter is 16 bits and saturates; it never wraps.

## Test plan
- Valid ID, back-to-back bits: stream 64'hA2000000_01B81C02 LSB-first (bytes 02,1C,B8,01,00,00,00,A2).
  - Expect `done` 2 cycles after the 64th accept, `crc_ok`=1, `crc_value`=0, `family_code`=8'h02, `rom_id`=64'hA2000000_01B81C02.
- Corrupt CRC: same stream with bit 63 flipped. Expect `crc_ok`=0, `crc_value`≠0, `done` pulse.
- Throttled stream: `bit_valid` asserted every 7th cycle with the valid ID. Expect identical results to the back-to-back case; `timeout`=0.
- Inter-bit timeout: TIMEOUT_CYCLES=100; send 10 bits, then hold `bit_valid` low.
  - Expect `timeout`=1 and a `done` pulse 100 cycles after the 10th accept.
  - Expect `crc_ok`=0 and `rom_id[9:0]` holding the sent bits.
- Abort collision: `abort` and a bit accept in the same cycle at bit 20.
  - Expect `aborted`=1, `done` the next cycle, the bit not stored, and `bit_ready` low after.
- Reset mid-read: deassert `rst_n` at bit 30. Expect all outputs 0 immediately; a subsequent full valid read passes.
